// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit period.
// Reused by the receiver and the future transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // 50 MHz system clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both stages reset to RESET_VAL so a line idling at that level shows no edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling driven by a bit-timer enable counter.
// Emits a one-cycle data_valid for good frames, frame_err for a low stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  logic rx_s;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clock(clock),
    .rst  (rst),
    .d    (rx),
    .q    (rx_s)
  );

  uart_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d;
  logic          fe_q, fe_d;
  logic          prev_q, prev_d;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
    // Tracked in every state so a line still low after STOP cannot retrigger.
    prev_d    = rx_s;

    case (state_q)
      IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == HALF_M1) begin
          timer_d   = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      prev_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      prev_q    <= prev_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a negedge monitor
// counts pulses and the main sequence checks them against hand-computed values.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock     (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state, written only here.
  int         dv_cnt = 0, fe_cnt = 0, both_cnt = 0, dv_long = 0, fe_long = 0;
  int         dv_cyc = 0, busy_rise_cyc = 0, busy_run = 0, last_run = 0;
  logic [7:0] dv_hist0 = 8'h00, dv_hist1 = 8'h00;
  logic       dv_prev = 1'b0, fe_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt   <= dv_cnt + 1;
      dv_cyc   <= cyc;
      dv_hist0 <= data_out;
      dv_hist1 <= dv_hist0;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (data_valid && frame_err) both_cnt <= both_cnt + 1;
    if (data_valid && dv_prev) dv_long <= dv_long + 1;
    if (frame_err && fe_prev) fe_long <= fe_long + 1;
    if (busy && !busy_prev) busy_rise_cyc <= cyc;
    if (busy) busy_run <= busy_run + 1;
    else if (busy_prev) begin
      last_run <= busy_run;
      busy_run <= 0;
    end
    dv_prev   <= data_valid;
    fe_prev   <= frame_err;
    busy_prev <= busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic drive_level(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_level(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_level(b[i], CPB);
    drive_level(stop_bit, CPB);
  endtask

  int dv0, fe0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_data_out", data_out, 8'h00);
    check_eq("rst_dv", data_valid, 1'b0);
    check_eq("rst_fe", frame_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
    drive_level(1'b1, 4);
    check_eq("post_rst_busy", busy, 1'b0);

    // Good frame 0xA5; decision cycle for START is the one before busy rises.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    drive_level(1'b1, 2 * CPB);
    $display("frame 0xA5 stop=1 -> data_out=0x%0h", data_out);
    check_eq("a5_data", data_out, 8'hA5);
    check_eq("a5_dv_cnt", dv_cnt - dv0, 1);
    check_eq("a5_fe_cnt", fe_cnt - fe0, 0);
    check_eq("a5_latency", dv_cyc - (busy_rise_cyc - 1), CPB / 2 + 9 * CPB + 1);

    // Bad stop bit
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    drive_level(1'b1, 2 * CPB);
    $display("frame 0x3C stop=0 -> data_out=0x%0h", data_out);
    check_eq("3c_fe_cnt", fe_cnt - fe0, 1);
    check_eq("3c_dv_cnt", dv_cnt - dv0, 0);
    check_eq("3c_data_kept", data_out, 8'hA5);

    // Start-bit glitch of 5 cycles
    dv0 = dv_cnt; fe0 = fe_cnt;
    drive_level(1'b0, 5);
    drive_level(1'b1, 3 * CPB);
    $display("glitch 5 cycles -> busy run %0d", last_run);
    check_eq("glitch_busy_le8", (last_run <= 8 && last_run > 0), 1'b1);
    check_eq("glitch_pulses", (dv_cnt - dv0) + (fe_cnt - fe0), 0);
    check_eq("glitch_idle", busy, 1'b0);

    // Back-to-back 0x00 then 0xFF
    dv0 = dv_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive_level(1'b1, 2 * CPB);
    $display("back-to-back 0x00,0xFF -> 0x%0h,0x%0h", dv_hist1, dv_hist0);
    check_eq("b2b_dv_cnt", dv_cnt - dv0, 2);
    check_eq("b2b_first", dv_hist1, 8'h00);
    check_eq("b2b_second", dv_hist0, 8'hFF);

    // Reset during bit 4 of 0x55, then 0x81
    dv0 = dv_cnt; fe0 = fe_cnt;
    drive_level(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_level(((8'h55 >> i) & 8'h01) != 0, CPB);
    drive_level(1'b1, 8);
    check_eq("mid_frame_busy", busy, 1'b1);
    rst = 1'b1;
    drive_level(1'b1, 3);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_data_out", data_out, 8'h00);
    rst = 1'b0;
    drive_level(1'b1, 2 * CPB);
    check_eq("abort_pulses", (dv_cnt - dv0) + (fe_cnt - fe0), 0);
    send_frame(8'h81, 1'b1);
    drive_level(1'b1, 2 * CPB);
    $display("after abort frame 0x81 -> data_out=0x%0h", data_out);
    check_eq("81_data", data_out, 8'h81);
    check_eq("81_dv_cnt", dv_cnt - dv0, 1);
    check_eq("81_fe_cnt", fe_cnt - fe0, 0);

    // Line held low for 30 bit times after a frame
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h5A, 1'b0);
    drive_level(1'b0, 30 * CPB);
    $display("break 30 bits -> fe %0d dv %0d", fe_cnt - fe0, dv_cnt - dv0);
    check_eq("break_fe_cnt", fe_cnt - fe0, 1);
    check_eq("break_dv_cnt", dv_cnt - dv0, 0);
    check_eq("break_idle", busy, 1'b0);
    drive_level(1'b1, 2 * CPB);
    check_eq("break_release_pulses", (dv_cnt - dv0) + (fe_cnt - fe0), 1);
    send_frame(8'h96, 1'b1);
    drive_level(1'b1, 2 * CPB);
    $display("frame 0x96 after break -> data_out=0x%0h", data_out);
    check_eq("96_data", data_out, 8'h96);
    check_eq("96_dv_cnt", dv_cnt - dv0, 1);

    // Pulse shape across the whole run
    check_eq("dv_fe_overlap", both_cnt, 0);
    check_eq("dv_width", dv_long, 0);
    check_eq("fe_width", fe_long, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
